// File: rtl/sar_adc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sar_adc_pkg
//  Description : Shared definitions for the SAR ADC digital back end. Holds
//                the default conversion width, the legal averaging range and
//                the result-buffer state encoding. The result struct itself is
//                width-dependent and is declared inside sar_code_averager.
//  Revision    : 1.0 - initial release
// ============================================================================
package sar_adc_pkg;

    // Default conversion code width (ADC resolution).
    localparam int SAR_N_DEFAULT = 10;

    // Largest supported log2 of samples per averaging block.
    localparam int LOG2_AVG_MAX  = 8;

    // Single-entry output buffer occupancy.
    typedef enum logic [0:0] {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

endpackage
`default_nettype wire

// File: rtl/sar_code_averager_if.sv
`default_nettype none
// ============================================================================
//  Module      : sar_code_averager_if
//  Description : Valid/ready result channel carrying one averaging block
//                result (sum, min, max, clip) to the digital back end.
//  Ports       : avg_sum   - exact block sum, N+LOG2_AVG bits
//                avg_min   - smallest code in block
//                avg_max   - largest code in block
//                avg_clip  - block contained a rail code
//                avg_valid - result held and not yet consumed
//                avg_ready - consumer accepts result
//  Modports    : master (result producer), slave (result consumer)
//  Revision    : 1.0 - initial release
// ============================================================================
interface sar_code_averager_if #(
    parameter int N        = 10,
    parameter int LOG2_AVG = 4
);
    logic [N+LOG2_AVG-1:0] avg_sum;
    logic [N-1:0]          avg_min;
    logic [N-1:0]          avg_max;
    logic                  avg_clip;
    logic                  avg_valid;
    logic                  avg_ready;

    modport master (
        output avg_sum, avg_min, avg_max, avg_clip, avg_valid,
        input  avg_ready
    );

    modport slave (
        input  avg_sum, avg_min, avg_max, avg_clip, avg_valid,
        output avg_ready
    );
endinterface
`default_nettype wire

// File: rtl/sar_code_averager.sv
`default_nettype none
// ============================================================================
//  Module      : sar_code_averager
//  Description : Accumulates 2^LOG2_AVG consecutive SAR conversion codes into
//                one block result (exact sum, min, max, clip) and holds it in
//                a single-entry valid/ready buffer. Blocks that complete while
//                the buffer is full and not being drained are dropped and
//                flagged on the sticky ovr output.
//  Ports       : clk        - conversion-domain clock
//                rst        - synchronous active-high reset
//                en         - accumulation enable; low abandons partial block
//                code_in    - conversion code
//                code_valid - one-cycle strobe per conversion
//                res        - result channel (master modport)
//                ovr        - sticky dropped-block flag
//                ovr_clr    - clears ovr (a simultaneous overrun wins)
//  Revision    : 1.0 - initial release
// ============================================================================
module sar_code_averager
    import sar_adc_pkg::*;
#(
    parameter int N        = SAR_N_DEFAULT,
    parameter int LOG2_AVG = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         en,
    input  wire logic [N-1:0] code_in,
    input  wire logic         code_valid,
    sar_code_averager_if.master res,
    output logic              ovr,
    input  wire logic         ovr_clr
);

    localparam int c_SUM_W = N + LOG2_AVG;
    // Keep the counter at least one bit wide so LOG2_AVG=0 elaborates; in that
    // case it is held at zero and every accepted sample is the last one.
    localparam int c_CNT_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'((1 << LOG2_AVG) - 1);
    localparam logic [N-1:0]       c_CODE_MAX = '1;

    typedef struct packed {
        logic [c_SUM_W-1:0] sum;
        logic [N-1:0]       min;
        logic [N-1:0]       max;
        logic               clip;
    } avg_result_t;

    // Running block state
    logic [c_SUM_W-1:0] r_acc;
    logic [c_CNT_W-1:0] r_cnt;
    logic [N-1:0]       r_min;
    logic [N-1:0]       r_max;
    logic               r_clip;

    // Output buffer
    buf_state_t  r_state;
    buf_state_t  w_state_next;
    avg_result_t r_result;
    logic        r_ovr;

    logic        w_accept;
    logic        w_done;
    logic        w_load;
    logic        w_ovr_set;
    avg_result_t w_cand;

    assign w_accept = en & code_valid;
    assign w_done   = w_accept & (r_cnt == c_CNT_LAST);

    // Candidate result always includes the current sample, so on the final
    // sample of a block it is exactly the block result.
    always_comb begin
        w_cand      = '0;
        w_cand.sum  = r_acc + c_SUM_W'(code_in);
        w_cand.min  = (code_in < r_min) ? code_in : r_min;
        w_cand.max  = (code_in > r_max) ? code_in : r_max;
        w_cand.clip = r_clip | (code_in == '0) | (code_in == c_CODE_MAX);
    end

    // Accumulator and min/max tracking. Completion and en=0 both return the
    // block to its cleared state so the next sample starts a new block.
    always_ff @(posedge clk) begin
        if (rst || !en || w_done) begin
            r_acc  <= '0;
            r_cnt  <= '0;
            r_min  <= c_CODE_MAX;
            r_max  <= '0;
            r_clip <= 1'b0;
        end else if (w_accept) begin
            r_acc  <= w_cand.sum;
            r_cnt  <= r_cnt + c_CNT_W'(1);
            r_min  <= w_cand.min;
            r_max  <= w_cand.max;
            r_clip <= w_cand.clip;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= BUF_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A completion arriving while the held result is being transferred
    // replaces it directly; only a completion against a stalled full buffer
    // is lost.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_ovr_set    = 1'b0;
        case (r_state)
            BUF_EMPTY: begin
                if (w_done) begin
                    w_state_next = BUF_FULL;
                    w_load       = 1'b1;
                end
            end
            BUF_FULL: begin
                if (w_done) begin
                    if (res.avg_ready) begin
                        w_load    = 1'b1;
                    end else begin
                        w_ovr_set = 1'b1;
                    end
                end else if (res.avg_ready) begin
                    w_state_next = BUF_EMPTY;
                end
            end
            default: begin
                w_state_next = BUF_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= '0;
        end else if (w_load) begin
            r_result <= w_cand;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovr <= 1'b0;
        end else if (w_ovr_set) begin
            r_ovr <= 1'b1;
        end else if (ovr_clr) begin
            r_ovr <= 1'b0;
        end
    end

    assign res.avg_sum   = r_result.sum;
    assign res.avg_min   = r_result.min;
    assign res.avg_max   = r_result.max;
    assign res.avg_clip  = r_result.clip;
    assign res.avg_valid = (r_state == BUF_FULL);
    assign ovr           = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_sar_code_averager.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sar_code_averager
//  Description : Scoreboard bench for sar_code_averager. Two instances share
//                the sample stream: LOG2_AVG=2 with driven avg_ready, and
//                LOG2_AVG=0 (pass-through) with avg_ready tied high. Expected
//                block results come from a block-level reference model that
//                gathers samples in a queue and reduces them arithmetically.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sar_code_averager;

    localparam int N   = 10;
    localparam int L   = 2;
    localparam int BLK = 1 << L;
    localparam int unsigned CMAX = (1 << N) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, en, code_valid, ovr_clr;
    logic [N-1:0] code_in;
    logic         ovr, ovr0;

    sar_code_averager_if #(.N(N), .LOG2_AVG(L)) res_if ();
    sar_code_averager_if #(.N(N), .LOG2_AVG(0)) res0_if ();

    assign res0_if.avg_ready = 1'b1;

    sar_code_averager #(.N(N), .LOG2_AVG(L)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .code_in    (code_in),
        .code_valid (code_valid),
        .res        (res_if),
        .ovr        (ovr),
        .ovr_clr    (ovr_clr)
    );

    sar_code_averager #(.N(N), .LOG2_AVG(0)) u_dut0 (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .code_in    (code_in),
        .code_valid (code_valid),
        .res        (res0_if),
        .ovr        (ovr0),
        .ovr_clr    (1'b0)
    );

    typedef struct {
        int unsigned sum;
        int unsigned mn;
        int unsigned mx;
        bit          clip;
    } res_t;

    res_t        q[$];
    res_t        q0[$];
    int unsigned samples[$];
    bit          m_full, m_ovr, m_full0, mon_on;
    int          n_vec, n_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic res_t block_of(input int unsigned s[$]);
        res_t r;
        r.sum  = 0;
        r.mn   = s[0];
        r.mx   = s[0];
        r.clip = 1'b0;
        foreach (s[i]) begin
            r.sum += s[i];
            if (s[i] < r.mn) r.mn = s[i];
            if (s[i] > r.mx) r.mx = s[i];
            if (s[i] == 0 || s[i] == CMAX) r.clip = 1'b1;
        end
        return r;
    endfunction

    // Reference behaviour for one clock edge, using the inputs presented to it.
    task automatic model_edge();
        bit          done;
        bit          ovr_set;
        res_t        r;
        int unsigned one[$];
        if (rst) begin
            samples.delete();
            q.delete();
            q0.delete();
            m_full  = 1'b0;
            m_ovr   = 1'b0;
            m_full0 = 1'b0;
            return;
        end
        // Pass-through instance: every accepted sample is a whole block.
        m_full0 = en && code_valid;
        if (m_full0) begin
            one.push_back(int'(code_in));
            q0.push_back(block_of(one));
        end
        done    = 1'b0;
        ovr_set = 1'b0;
        if (!en) begin
            samples.delete();
        end else if (code_valid) begin
            samples.push_back(int'(code_in));
            if (samples.size() == BLK) begin
                r = block_of(samples);
                samples.delete();
                done = 1'b1;
            end
        end
        if (done) begin
            if (!m_full || res_if.avg_ready) begin
                q.push_back(r);
                m_full = 1'b1;
            end else begin
                ovr_set = 1'b1;
            end
        end else if (m_full && res_if.avg_ready) begin
            m_full = 1'b0;
        end
        if (ovr_set) m_ovr = 1'b1;
        else if (ovr_clr) m_ovr = 1'b0;
    endtask

    task automatic drive(input bit e, input bit cv, input int unsigned c,
                         input bit rdy, input bit clr, input bit r);
        en               = e;
        code_valid       = cv;
        code_in          = N'(c);
        res_if.avg_ready = rdy;
        ovr_clr          = clr;
        rst              = r;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Monitor: compares held results against the scoreboard every cycle the
    // buffer is full, and retires an entry when a transfer is about to occur.
    always @(negedge clk) begin
        if (mon_on) begin
            check("avg_valid", 32'(res_if.avg_valid), 32'(m_full));
            check("ovr", 32'(ovr), 32'(m_ovr));
            if (res_if.avg_valid === 1'b1) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL result: avg_valid=1 but no expected result pending at %0t", $time);
                end else begin
                    check("avg_sum", 32'(res_if.avg_sum), q[0].sum);
                    check("avg_min", 32'(res_if.avg_min), q[0].mn);
                    check("avg_max", 32'(res_if.avg_max), q[0].mx);
                    check("avg_clip", 32'(res_if.avg_clip), 32'(q[0].clip));
                    if (res_if.avg_ready) void'(q.pop_front());
                end
            end
            check("pt_valid", 32'(res0_if.avg_valid), 32'(m_full0));
            if (res0_if.avg_valid === 1'b1 && q0.size() != 0) begin
                check("pt_sum", 32'(res0_if.avg_sum), q0[0].sum);
                check("pt_min", 32'(res0_if.avg_min), q0[0].mn);
                check("pt_max", 32'(res0_if.avg_max), q0[0].mx);
                check("pt_clip", 32'(res0_if.avg_clip), 32'(q0[0].clip));
                void'(q0.pop_front());
            end
        end
    end

    initial begin
        int unsigned t2[4];
        bit          e, cv, rdy, clr, r;
        int unsigned c, sel;

        n_vec  = 0;
        n_err  = 0;
        mon_on = 1'b0;
        drive(0, 0, 0, 1, 0, 1);
        drive(0, 0, 0, 1, 0, 1);
        mon_on = 1'b1;

        // Reset state
        check("rst_sum", 32'(res_if.avg_sum), 0);
        check("rst_min", 32'(res_if.avg_min), 0);
        check("rst_max", 32'(res_if.avg_max), 0);
        check("rst_clip", 32'(res_if.avg_clip), 0);
        check("rst_valid", 32'(res_if.avg_valid), 0);
        check("rst_ovr", 32'(ovr), 0);

        // Four back-to-back codes, consumer ready
        for (int i = 0; i < 4; i++) drive(1, 1, 100 + i, 1, 0, 0);
        check("t1_sum", 32'(res_if.avg_sum), 406);
        check("t1_min", 32'(res_if.avg_min), 100);
        check("t1_max", 32'(res_if.avg_max), 103);
        check("t1_clip", 32'(res_if.avg_clip), 0);
        check("t1_valid", 32'(res_if.avg_valid), 1);
        drive(1, 0, 0, 1, 0, 0);
        check("t1_valid_drop", 32'(res_if.avg_valid), 0);

        // Rail codes
        t2 = '{0, 1023, 512, 512};
        for (int i = 0; i < 4; i++) drive(1, 1, t2[i], 1, 0, 0);
        check("t2_sum", 32'(res_if.avg_sum), 2047);
        check("t2_min", 32'(res_if.avg_min), 0);
        check("t2_max", 32'(res_if.avg_max), 1023);
        check("t2_clip", 32'(res_if.avg_clip), 1);
        drive(1, 0, 0, 1, 0, 0);

        // Back-pressure: second block dropped, first held
        for (int i = 0; i < 8; i++) drive(1, 1, 5, 0, 0, 0);
        check("t3_sum", 32'(res_if.avg_sum), 20);
        check("t3_valid", 32'(res_if.avg_valid), 1);
        check("t3_ovr", 32'(ovr), 1);
        drive(1, 0, 0, 1, 0, 0);
        check("t3_valid_after", 32'(res_if.avg_valid), 0);
        check("t3_ovr_sticky", 32'(ovr), 1);
        drive(1, 0, 0, 0, 1, 0);
        check("t3_ovr_clr", 32'(ovr), 0);

        // en=0 abandons the partial block
        drive(1, 1, 7, 1, 0, 0);
        drive(1, 1, 7, 1, 0, 0);
        drive(0, 1, 7, 1, 0, 0);
        for (int i = 0; i < 4; i++) drive(1, 1, 10, 1, 0, 0);
        check("t4_sum", 32'(res_if.avg_sum), 40);
        check("t4_min", 32'(res_if.avg_min), 10);
        check("t4_max", 32'(res_if.avg_max), 10);
        drive(1, 0, 0, 1, 0, 0);

        // Reset mid-block with buffer full
        for (int i = 0; i < 4; i++) drive(1, 1, 9, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(1, 1, 9, 0, 0, 0);
        drive(1, 1, 9, 0, 0, 1);
        check("t5_sum", 32'(res_if.avg_sum), 0);
        check("t5_max", 32'(res_if.avg_max), 0);
        check("t5_valid", 32'(res_if.avg_valid), 0);
        check("t5_ovr", 32'(ovr), 0);
        for (int i = 0; i < 4; i++) drive(1, 1, 1, 1, 0, 0);
        check("t5_sum_after", 32'(res_if.avg_sum), 4);
        drive(1, 0, 0, 1, 0, 0);

        // Pass-through instance
        drive(1, 1, 777, 1, 0, 0);
        check("pt777_sum", 32'(res0_if.avg_sum), 777);
        check("pt777_min", 32'(res0_if.avg_min), 777);
        check("pt777_max", 32'(res0_if.avg_max), 777);
        check("pt777_clip", 32'(res0_if.avg_clip), 0);
        drive(1, 1, 1023, 1, 0, 0);
        check("pt1023_sum", 32'(res0_if.avg_sum), 1023);
        check("pt1023_clip", 32'(res0_if.avg_clip), 1);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            e   = ($urandom_range(0, 9) != 0);
            cv  = ($urandom_range(0, 9) < 7);
            sel = $urandom_range(0, 7);
            c   = (sel == 0) ? 0 : (sel == 1) ? CMAX : $urandom_range(0, CMAX);
            rdy = ($urandom_range(0, 1) == 1);
            clr = ($urandom_range(0, 19) == 0);
            r   = ($urandom_range(0, 199) == 0);
            drive(e, cv, c, rdy, clr, r);
        end
        // Sustained stream with consumer always ready: nothing may be lost
        for (int k = 0; k < 200; k++) drive(1, 1, $urandom_range(0, CMAX), 1, 0, 0);
        check("no_loss_ovr", 32'(ovr), 32'(m_ovr));
        drive(1, 0, 0, 1, 0, 0);
        drive(1, 0, 0, 1, 0, 0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sar_code_averager.md
# sar_code_averager

Downstream consumer of the SAR ADC conversion word. Accumulates 2^LOG2_AVG consecutive conversion codes into one block result: exact sum, block min, block max and a clip flag. It presents that result on a single-entry valid/ready output buffer to the digital back end. Sticky overrun flagging covers blocks lost to back-pressure.

## Interface
- N, 10, conversion code width (matches ADC resolution)
- LOG2_AVG, 4, log2 of samples per block; legal range 0..8
- clk  in  1  conversion-domain clock
- rst  in  1  reset; synchronous, active-high
- en  in  1  accumulation enable
- code_in  in  N  conversion code from ADC output latch
- code_valid  in  1  one-cycle strobe per new conversion; may be asserted back-to-back
- avg_sum  out  N+LOG2_AVG  exact block sum (mean in fixed point, LOG2_AVG fraction bits)
- avg_min  out  N  smallest code in block
- avg_max  out  N  largest code in block
- avg_clip  out  1  block contained code 0 or code 2^N-1
- avg_valid  out  1  result buffer holds unconsumed result
- avg_ready  in  1  consumer accepts result
- ovr  out  1  sticky: at least one completed block was dropped
- ovr_clr  in  1  clears ovr

## Operation
- Per cycle with en=1 and code_valid=1, the block accepts a sample:
  - acc += code_in.
  - run_min, run_max and run_clip update, including the current sample.
  - cnt increments.
- Block completes when a sample is accepted with cnt == 2^LOG2_AVG-1:
  - Candidate result = acc+code_in, min/max/clip including that sample.
  - acc, cnt and run_clip clear. run_min loads 2^N-1 and run_max loads 0.
  - All of this happens in the same cycle, so the next sample starts a fresh block with no gap.
- Output buffer states:
  - EMPTY: avg_valid=0.
  - FULL: avg_valid=1.
- Buffer transitions:
  - EMPTY plus completion -> FULL, candidate loaded.
  - FULL with avg_ready=1 and no completion -> EMPTY.
  - FULL with avg_ready=1 and completion -> stays FULL, candidate loaded. No overrun.
  - FULL with avg_ready=0 and completion -> candidate discarded, old result kept, ovr set.
- Accumulation continues while the buffer is FULL.
- en=0:
  - code_valid is ignored.
  - The partial block is abandoned: acc, cnt, run_min, run_max and run_clip return to their cleared values.
  - The output buffer and ovr are unaffected.
- ovr_clr=1 clears ovr. If an overrun occurs in the same cycle, set wins.
- LOG2_AVG=0: every accepted sample completes a block. This is pass-through: avg_sum=avg_min=avg_max=code_in, with clip computed.
- Arithmetic:
  - Unsigned only.
  - Accumulator width N+LOG2_AVG, which cannot overflow.
  - No rounding or truncation.

## Timing
- Reset values:
  - avg_sum=0, avg_min=0, avg_max=0, avg_clip=0, avg_valid=0, ovr=0.
  - Internal: acc=0, cnt=0, run_min=2^N-1, run_max=0, run_clip=0.
- Reset mid-block or with the buffer FULL discards everything. The first accepted sample after rst releases is sample 0 of a new block.
- Latency: result outputs and avg_valid assert on the clock edge after the cycle in which the last sample of the block is accepted.
- Handshake:
  - A transfer occurs on an edge where avg_valid=1 and avg_ready=1.
  - Result outputs are stable while avg_valid=1 and no transfer occurs.
  - avg_ready may toggle freely. avg_valid does not depend combinationally on avg_ready.
- Throughput: one sample per cycle sustained. With avg_ready tied high, there is no loss at any LOG2_AVG.

## Structure
- Shared package sar_adc_pkg:
  - Default N constant.
  - avg_result_t packed struct {sum, min, max, clip}, parameterised by width via a localparam in the module.
  - Buffer state enum {BUF_EMPTY, BUF_FULL}.
- Single module, no sub-module. Accumulator and min/max tracking are inline.

## Test plan
- N=10, LOG2_AVG=2, avg_ready=1, codes 100,101,102,103 back-to-back -> one cycle later avg_valid=1 for 1 cycle, avg_sum=406, min=100, max=103, clip=0.
- Same config, codes 0,1023,512,512 -> avg_sum=2047, min=0, max=1023, clip=1.
- Same config, avg_ready=0, 8 samples of 5 -> first block held (sum=20) and second block dropped, ovr=1. Then avg_ready=1 for one cycle -> transfer, avg_valid=0. ovr_clr -> ovr=0.
- Same config, two samples of 7, en=0 for 1 cycle, en=1, four samples of 10 -> avg_sum=40, min=max=10.
- Reset variant: rst asserted after 3 of 4 samples -> all outputs zero next cycle; subsequent 4 samples of 1 -> avg_sum=4.
- N=10, LOG2_AVG=0, code 777 with code_valid -> next cycle avg_sum=avg_min=avg_max=777, clip=0. Code 1023 -> clip=1.
